ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
//  Parametrised EX->MEM pipeline stage with valid/ready handshake, stall, flush and optional skid buffer.
//  Carries control (RegWrite, MemtoReg, MemWrite, MemRead, MemSize) and data (ALU result, store data, Rd).
//  Sits between the execute stage and the data-memory stage.
//  Lets a memory stall back-pressure EX without a combinational ready path when SKID=1.
// PARAMETERS
//  XLEN        64  data width of AluResult/Datain
//  REG_ADDR_W  5   register-index width
//  SKID        1   1: 2-entry skid buffer (registered in_ready); 0: single register (combinational in_ready)
//  ZERO_RD_WR  0   0: RegWrite_Out forced 0 when Rd_out==0; 1: pass RegWrite unchanged
// PORTS
//  clk           in   1           rising-edge clock
//  reset         in   1           asynchronous reset, active-low (reset==0 resets)
//  flush         in   1           synchronous squash of all held entries (branch/exception)
//  in_valid      in   1           EX presents a valid instruction
//  in_ready      out  1           stage accepts this cycle (transfer = in_valid & in_ready)
//  RegWrite      in   1           control: write-back enable
//  MemtoReg      in   1           control: select memory data for WB
//  MemWrite      in   1           control: store
//  MemRead       in   1           control: load
//  MemSize       in   2           00 byte, 01 half, 10 word, 11 double
//  AluResult     in   XLEN        ALU result / effective address
//  Datain        in   XLEN        store data (rs2)
//  Rd_in         in   REG_ADDR_W  destination register
//  out_valid     out  1           MEM-side entry valid
//  out_ready     in   1           MEM accepts (transfer = out_valid & out_ready)
//  RegWrite_Out, MemtoReg_Out, MemWrite_Out, MemRead_Out  out  1  registered controls
//  MemSize_Out   out  2           registered MemSize
//  AluOut        out  XLEN        registered AluResult
//  DataOut       out  XLEN        registered Datain
//  Rd_out        out  REG_ADDR_W  registered Rd_in
// BEHAVIOUR
//  Reset (reset==0, async): all outputs and internal state 0; in_ready 0 while reset asserted, 1 first cycle after release.
//  Latency: accepted entry appears on outputs the next cycle; order strictly FIFO.
//  Bubble rule: whenever out_valid==0, RegWrite_Out/MemWrite_Out/MemRead_Out/MemtoReg_Out are 0; data outputs hold last value.
//  SKID=1 state machine, state = occupancy:
//   EMPTY: in_ready=1; accept -> FULL1.
//   FULL1: in_ready=1; accept & !pop -> FULL2 (new entry into skid reg); accept & pop -> FULL1 (main reg reloaded); pop only -> EMPTY.
//   FULL2: in_ready=0; pop -> FULL1, skid reg moves to main reg same edge.
//  in_ready is a flop output (state!=FULL2); no in_ready dependence on out_ready.
//  SKID=0: single register; in_ready = !out_valid | out_ready (combinational); load on accept, clear valid on pop-only.
//  Stall: out_valid & !out_ready holds every output bit stable.
//  Flush: highest priority; next edge -> EMPTY, out_valid 0, controls 0; any in_valid that cycle is discarded.
//  Flush while FULL2 drops both entries; flush during reset has no effect.
//  ZERO_RD_WR=0: entry with Rd_in==0 captured with RegWrite 0 (MemWrite/MemRead unaffected).
//  No arithmetic; widths pass through unchanged. MemWrite & MemRead both 1 is passed through; MEM stage flags it.
// STRUCTURE
//  Shared package pipe_pkg: typedef struct packed ex_mem_ctrl_t {RegWrite, MemtoReg, MemWrite, MemRead, MemSize};
//   enum mem_size_e {MS_B, MS_H, MS_W, MS_D}; enum skid_state_e {EMPTY, FULL1, FULL2}.
//  Payload packed as {ctrl, AluResult, Datain, Rd} into one struct.
//  One sub-module: skid_reg (generic width, holds one payload + valid), instantiated twice under SKID=1,
//   once under SKID=0. The FSM stays in ex_mem_stage.
// TESTING
//  1. Reset low mid-traffic with FULL2 -> all outputs 0 immediately; in_ready=1 one cycle after release.
//  2. Stream AluResult=0x10,0x20,0x30 with out_ready=1 -> AluOut 0x10,0x20,0x30 on consecutive cycles, in_ready stays 1.
//  3. out_ready=0 with 3 offered entries (SKID=1) -> 2 accepted, in_ready=0 after second; then out_ready=1 -> drains in order, no loss/dup.
//  4. flush with FULL2 and in_valid=1 (MemWrite=1) -> next cycle out_valid=0, MemWrite_Out=0; later entries unaffected.
//  5. Rd_in=0, RegWrite=1, ZERO_RD_WR=0 -> RegWrite_Out=0, Rd_out=0; with ZERO_RD_WR=1 -> RegWrite_Out=1.
//  6. SKID=0 build, out_ready toggled 1/0 per cycle -> in_ready tracks !out_valid|out_ready same cycle; outputs stable while stalled.

Source files
------------

// File: rtl/ex_mem_stage_pkg.sv
// Shared EX->MEM pipeline types: control bundle, access size and skid occupancy states.
package pipe_pkg;

  typedef enum logic [1:0] {
    MS_B = 2'b00,
    MS_H = 2'b01,
    MS_W = 2'b10,
    MS_D = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL1 = 2'd1,
    FULL2 = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic      RegWrite;
    logic      MemtoReg;
    logic      MemWrite;
    logic      MemRead;
    mem_size_e MemSize;
  } ex_mem_ctrl_t;

  localparam int unsigned CTRL_W = $bits(ex_mem_ctrl_t);

  // Zero the side-effecting control flags of a bubble; MemSize is treated as data and kept
  function automatic ex_mem_ctrl_t bubbleCtrl(input ex_mem_ctrl_t c, input logic v);
    ex_mem_ctrl_t r;
    r          = c;
    r.RegWrite = c.RegWrite & v;
    r.MemtoReg = c.MemtoReg & v;
    r.MemWrite = c.MemWrite & v;
    r.MemRead  = c.MemRead & v;
    return r;
  endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX->MEM stage bus: EX-side offer, MEM-side presentation, and both handshakes.
interface ex_mem_stage_if #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned REG_ADDR_W = 5
);

  logic                  in_valid;
  logic                  in_ready;
  logic                  RegWrite;
  logic                  MemtoReg;
  logic                  MemWrite;
  logic                  MemRead;
  logic [1:0]            MemSize;
  logic [XLEN-1:0]       AluResult;
  logic [XLEN-1:0]       Datain;
  logic [REG_ADDR_W-1:0] Rd_in;

  logic                  out_valid;
  logic                  out_ready;
  logic                  RegWrite_Out;
  logic                  MemtoReg_Out;
  logic                  MemWrite_Out;
  logic                  MemRead_Out;
  logic [1:0]            MemSize_Out;
  logic [XLEN-1:0]       AluOut;
  logic [XLEN-1:0]       DataOut;
  logic [REG_ADDR_W-1:0] Rd_out;

  // Surrounding pipeline: drives EX offer and MEM acceptance
  modport master (
    output in_valid, RegWrite, MemtoReg, MemWrite, MemRead, MemSize,
           AluResult, Datain, Rd_in, out_ready,
    input  in_ready, out_valid, RegWrite_Out, MemtoReg_Out, MemWrite_Out,
           MemRead_Out, MemSize_Out, AluOut, DataOut, Rd_out
  );

  // The stage itself
  modport slave (
    input  in_valid, RegWrite, MemtoReg, MemWrite, MemRead, MemSize,
           AluResult, Datain, Rd_in, out_ready,
    output in_ready, out_valid, RegWrite_Out, MemtoReg_Out, MemWrite_Out,
           MemRead_Out, MemSize_Out, AluOut, DataOut, Rd_out
  );

endinterface

// File: rtl/ex_mem_stage_skid_reg.sv
// One payload register plus its valid bit; load wins over clear.
module skid_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  // Payload holds its last value when the entry is cleared
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (clr) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline stage: valid/ready handshake, flush, optional 2-entry skid buffer.
module ex_mem_stage
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned REG_ADDR_W = 5,
  parameter bit          SKID       = 1'b1,
  parameter bit          ZERO_RD_WR = 1'b0
) (
  input logic           clk,
  input logic           reset,
  input logic           flush,
  ex_mem_stage_if.slave bus
);

  typedef struct packed {
    ex_mem_ctrl_t          ctrl;
    logic [XLEN-1:0]       alu;
    logic [XLEN-1:0]       data;
    logic [REG_ADDR_W-1:0] rd;
  } payload_t;

  localparam int unsigned PAYLOAD_W = $bits(payload_t);

  payload_t     inPayload;
  payload_t     outPayload;
  ex_mem_ctrl_t outCtrl;
  logic         outValid;
  logic         accept;
  logic         pop;

  // Pack the EX offer; a write to x0 is demoted to no write unless configured otherwise
  always_comb begin
    inPayload               = '0;
    inPayload.ctrl.RegWrite = bus.RegWrite & (ZERO_RD_WR | (bus.Rd_in != '0));
    inPayload.ctrl.MemtoReg = bus.MemtoReg;
    inPayload.ctrl.MemWrite = bus.MemWrite;
    inPayload.ctrl.MemRead  = bus.MemRead;
    inPayload.ctrl.MemSize  = mem_size_e'(bus.MemSize);
    inPayload.alu           = bus.AluResult;
    inPayload.data          = bus.Datain;
    inPayload.rd            = bus.Rd_in;
  end

  assign pop    = outValid & bus.out_ready;
  assign accept = bus.in_valid & bus.in_ready & ~flush;

  if (SKID) begin : g_skid
    skid_state_e          stateQ;
    skid_state_e          stateNext;
    logic                 inReadyQ;
    logic                 mainLoad;
    logic                 mainClr;
    logic                 skidLoad;
    logic                 skidClr;
    logic                 skidValid;
    payload_t             mainD;
    logic [PAYLOAD_W-1:0] mainQ;
    logic [PAYLOAD_W-1:0] skidQ;

    // Occupancy register; in_ready is registered so it never depends on out_ready
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        stateQ   <= EMPTY;
        inReadyQ <= 1'b0;
      end else begin
        stateQ   <= stateNext;
        inReadyQ <= (stateNext != FULL2);
      end
    end

    // Occupancy transitions and register load/clear strobes; flush overrides everything
    always_comb begin
      stateNext = stateQ;
      mainLoad  = 1'b0;
      mainClr   = 1'b0;
      skidLoad  = 1'b0;
      skidClr   = 1'b0;
      mainD     = inPayload;
      if (flush) begin
        stateNext = EMPTY;
        mainClr   = 1'b1;
        skidClr   = 1'b1;
      end else begin
        case (stateQ)
          EMPTY: begin
            if (accept) begin
              mainLoad  = 1'b1;
              stateNext = FULL1;
            end
          end
          FULL1: begin
            if (accept && pop) begin
              mainLoad = 1'b1;
            end else if (accept) begin
              skidLoad  = 1'b1;
              stateNext = FULL2;
            end else if (pop) begin
              mainClr   = 1'b1;
              stateNext = EMPTY;
            end
          end
          FULL2: begin
            if (pop && skidValid) begin
              mainLoad  = 1'b1;
              mainD     = payload_t'(skidQ);
              skidClr   = 1'b1;
              stateNext = FULL1;
            end
          end
          default: begin
            stateNext = EMPTY;
            mainClr   = 1'b1;
            skidClr   = 1'b1;
          end
        endcase
      end
    end

    skid_reg #(.W(PAYLOAD_W)) uMain (
      .clk   (clk),
      .reset (reset),
      .load  (mainLoad),
      .clr   (mainClr),
      .d     (mainD),
      .valid (outValid),
      .q     (mainQ)
    );

    skid_reg #(.W(PAYLOAD_W)) uSkid (
      .clk   (clk),
      .reset (reset),
      .load  (skidLoad),
      .clr   (skidClr),
      .d     (inPayload),
      .valid (skidValid),
      .q     (skidQ)
    );

    assign bus.in_ready = inReadyQ;
    assign outPayload   = payload_t'(mainQ);
  end else begin : g_single
    logic                 rstDoneQ;
    logic [PAYLOAD_W-1:0] mainQ;

    // Keeps the combinational in_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rstDoneQ <= 1'b0;
      end else begin
        rstDoneQ <= 1'b1;
      end
    end

    skid_reg #(.W(PAYLOAD_W)) uMain (
      .clk   (clk),
      .reset (reset),
      .load  (accept),
      .clr   (flush | pop),
      .d     (inPayload),
      .valid (outValid),
      .q     (mainQ)
    );

    assign bus.in_ready = rstDoneQ & (~outValid | bus.out_ready);
    assign outPayload   = payload_t'(mainQ);
  end

  assign outCtrl          = bubbleCtrl(outPayload.ctrl, outValid);
  assign bus.out_valid    = outValid;
  assign bus.RegWrite_Out = outCtrl.RegWrite;
  assign bus.MemtoReg_Out = outCtrl.MemtoReg;
  assign bus.MemWrite_Out = outCtrl.MemWrite;
  assign bus.MemRead_Out  = outCtrl.MemRead;
  assign bus.MemSize_Out  = outCtrl.MemSize;
  assign bus.AluOut       = outPayload.alu;
  assign bus.DataOut      = outPayload.data;
  assign bus.Rd_out       = outPayload.rd;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench: dut0 = skid buffer with x0 write suppression, dut1 = single register passing RegWrite.
module tb_ex_mem_stage;

  typedef struct packed {
    logic        RegWrite;
    logic        MemtoReg;
    logic        MemWrite;
    logic        MemRead;
    logic [1:0]  size;
    logic [63:0] alu;
    logic [63:0] data;
    logic [4:0]  rd;
  } item_t;

  logic  clk;
  logic  reset;
  logic  flushS    [2];
  logic  drvValid  [2];
  logic  outRdy    [2];
  item_t drv       [2];
  logic  vValid    [2];
  logic  vInRdy    [2];
  item_t vOut      [2];
  logic  prevRst   [2];
  logic  prevStall [2];
  item_t snap      [2];
  item_t expQ      [2][$];

  int total = 0;
  int bad   = 0;

  ex_mem_stage_if #(.XLEN(64), .REG_ADDR_W(5)) ifA ();
  ex_mem_stage_if #(.XLEN(64), .REG_ADDR_W(5)) ifB ();

  ex_mem_stage #(.XLEN(64), .REG_ADDR_W(5), .SKID(1'b1), .ZERO_RD_WR(1'b0)) dutA (
    .clk   (clk),
    .reset (reset),
    .flush (flushS[0]),
    .bus   (ifA)
  );

  ex_mem_stage #(.XLEN(64), .REG_ADDR_W(5), .SKID(1'b0), .ZERO_RD_WR(1'b1)) dutB (
    .clk   (clk),
    .reset (reset),
    .flush (flushS[1]),
    .bus   (ifB)
  );

  assign ifA.in_valid  = drvValid[0];
  assign ifA.out_ready = outRdy[0];
  assign ifA.RegWrite  = drv[0].RegWrite;
  assign ifA.MemtoReg  = drv[0].MemtoReg;
  assign ifA.MemWrite  = drv[0].MemWrite;
  assign ifA.MemRead   = drv[0].MemRead;
  assign ifA.MemSize   = drv[0].size;
  assign ifA.AluResult = drv[0].alu;
  assign ifA.Datain    = drv[0].data;
  assign ifA.Rd_in     = drv[0].rd;
  assign ifB.in_valid  = drvValid[1];
  assign ifB.out_ready = outRdy[1];
  assign ifB.RegWrite  = drv[1].RegWrite;
  assign ifB.MemtoReg  = drv[1].MemtoReg;
  assign ifB.MemWrite  = drv[1].MemWrite;
  assign ifB.MemRead   = drv[1].MemRead;
  assign ifB.MemSize   = drv[1].size;
  assign ifB.AluResult = drv[1].alu;
  assign ifB.Datain    = drv[1].data;
  assign ifB.Rd_in     = drv[1].rd;

  assign vValid[0] = ifA.out_valid;
  assign vInRdy[0] = ifA.in_ready;
  assign vOut[0]   = {ifA.RegWrite_Out, ifA.MemtoReg_Out, ifA.MemWrite_Out, ifA.MemRead_Out,
                      ifA.MemSize_Out, ifA.AluOut, ifA.DataOut, ifA.Rd_out};
  assign vValid[1] = ifB.out_valid;
  assign vInRdy[1] = ifB.in_ready;
  assign vOut[1]   = {ifB.RegWrite_Out, ifB.MemtoReg_Out, ifB.MemWrite_Out, ifB.MemRead_Out,
                      ifB.MemSize_Out, ifB.AluOut, ifB.DataOut, ifB.Rd_out};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int d, input string name, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t got=%h exp=%h", name, d, $time, got, exp);
    end
  endtask

  // Reference: the stage is a FIFO of depth 2 (skid) or 1; x0 writes dropped only on dut0
  function automatic item_t model(input int d, input item_t e);
    item_t r;
    r = e;
    if (d == 0 && e.rd == 5'd0) r.RegWrite = 1'b0;
    return r;
  endfunction

  function automatic item_t randItem();
    item_t e;
    e.RegWrite = 1'($urandom);
    e.MemtoReg = 1'($urandom);
    e.MemWrite = 1'($urandom);
    e.MemRead  = 1'($urandom);
    e.size     = 2'($urandom);
    e.alu      = {$urandom, $urandom};
    e.data     = {$urandom, $urandom};
    e.rd       = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    return e;
  endfunction

  // Monitor: compares whatever the DUT presents against the scoreboard queue
  task automatic monitor(input int d);
    item_t o;
    item_t e;
    logic  v;
    logic  ir;
    logic  rdy;
    o   = vOut[d];
    v   = vValid[d];
    ir  = vInRdy[d];
    rdy = outRdy[d];
    if (!reset) begin
      chk(d, "reset_zero", 256'({v, ir, o}), 256'(0));
      prevRst[d]   = 1'b0;
      prevStall[d] = 1'b0;
      return;
    end
    if (!prevRst[d]) begin
      chk(d, "release_in_ready", 256'({v, ir}), 256'(0));
      prevRst[d]   = 1'b1;
      prevStall[d] = 1'b0;
      return;
    end
    chk(d, "out_valid", 256'(v), 256'(expQ[d].size() != 0));
    if (d == 0) chk(d, "in_ready_skid", 256'(ir), 256'(expQ[d].size() < 2));
    else        chk(d, "in_ready_comb", 256'(ir), 256'(!v || rdy));
    if (!v) chk(d, "bubble_ctrl", 256'({o.RegWrite, o.MemtoReg, o.MemWrite, o.MemRead}), 256'(0));
    if (prevStall[d]) chk(d, "stall_hold", 256'(o), 256'(snap[d]));
    if (v && rdy && expQ[d].size() != 0) begin
      e = expQ[d].pop_front();
      chk(d, "entry", 256'(o), 256'(e));
    end
    prevStall[d] = v && !rdy && !flushS[d];
    snap[d]      = o;
  endtask

  always @(negedge clk) monitor(0);
  always @(negedge clk) monitor(1);

  // One cycle: record what the stage accepted (or lost to flush/reset), then step to the next drive point
  task automatic tick();
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (!reset || flushS[d]) expQ[d].delete();
      else if (drvValid[d] && vInRdy[d]) expQ[d].push_back(model(d, drv[d]));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int d, input item_t e);
    drv[d]      = e;
    drvValid[d] = 1'b1;
    tick();
  endtask

  initial begin
    item_t e;
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      flushS[d]    = 1'b0;
      drvValid[d]  = 1'b0;
      outRdy[d]    = 1'b1;
      drv[d]       = '0;
      prevRst[d]   = 1'b0;
      prevStall[d] = 1'b0;
      snap[d]      = '0;
    end
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();

    // Back-to-back stream with MEM always ready
    for (int i = 1; i <= 3; i++) begin
      e     = randItem();
      e.alu = 64'(i * 16);
      offer(0, e);
    end
    drvValid[0] = 1'b0;
    repeat (3) tick();

    // MEM stalled: two entries fit, third is refused, then drain in order
    outRdy[0] = 1'b0;
    for (int i = 0; i < 3; i++) offer(0, randItem());
    chk(0, "full2_blocks", 256'(vInRdy[0]), 256'(0));
    drvValid[0] = 1'b0;
    outRdy[0]   = 1'b1;
    repeat (4) tick();

    // Flush while holding two entries, with a store offered the same cycle
    outRdy[0] = 1'b0;
    for (int i = 0; i < 2; i++) offer(0, randItem());
    e          = randItem();
    e.MemWrite = 1'b1;
    flushS[0]  = 1'b1;
    offer(0, e);
    flushS[0]   = 1'b0;
    drvValid[0] = 1'b0;
    outRdy[0]   = 1'b1;
    tick();
    chk(0, "flush_memwrite", 256'({vValid[0], ifA.MemWrite_Out}), 256'(0));
    for (int i = 0; i < 2; i++) offer(0, randItem());
    drvValid[0] = 1'b0;
    repeat (3) tick();

    // Write to x0 on both configurations
    e          = randItem();
    e.rd       = 5'd0;
    e.RegWrite = 1'b1;
    drv[0] = e; drvValid[0] = 1'b1;
    drv[1] = e; drvValid[1] = 1'b1;
    tick();
    drvValid[0] = 1'b0;
    drvValid[1] = 1'b0;
    chk(0, "x0_regwrite", 256'({ifA.RegWrite_Out, ifA.Rd_out}), 256'(0));
    chk(1, "x0_regwrite", 256'({ifB.RegWrite_Out, ifB.Rd_out}), 256'({1'b1, 5'd0}));
    repeat (2) tick();

    // Asynchronous reset while the skid buffer is full
    outRdy[0] = 1'b0;
    for (int i = 0; i < 2; i++) offer(0, randItem());
    drvValid[0] = 1'b0;
    reset = 1'b0;
    #1;
    chk(0, "async_reset", 256'({ifA.out_valid, ifA.in_ready, ifA.AluOut, ifA.MemWrite_Out}), 256'(0));
    repeat (2) tick();
    outRdy[0] = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    chk(0, "in_ready_after_release", 256'(vInRdy[0]), 256'(1));

    // Single-register build with MEM ready toggling every cycle
    for (int i = 0; i < 40; i++) begin
      outRdy[1]   = 1'(i % 2);
      drv[1]      = randItem();
      drvValid[1] = ($urandom_range(0, 3) != 0);
      tick();
    end
    drvValid[1] = 1'b0;
    outRdy[1]   = 1'b1;
    repeat (3) tick();

    // Random traffic on both, with occasional flushes
    for (int i = 0; i < 500; i++) begin
      for (int d = 0; d < 2; d++) begin
        drv[d]      = randItem();
        drvValid[d] = ($urandom_range(0, 9) < 7);
        outRdy[d]   = ($urandom_range(0, 9) < 6);
        flushS[d]   = ($urandom_range(0, 24) == 0);
      end
      tick();
    end

    for (int d = 0; d < 2; d++) begin
      drvValid[d] = 1'b0;
      flushS[d]   = 1'b0;
      outRdy[d]   = 1'b1;
    end
    for (int i = 0; i < 10 && (expQ[0].size() + expQ[1].size()) != 0; i++) tick();
    chk(0, "drain", 256'(expQ[0].size() + expQ[1].size()), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
